// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, flag struct and chunk-width helper for the add/sub pipeline
//
// Contents:
//   OP_ADD / OP_SUB  encoding of the sub input (0 = add, 1 = subtract)
//   flags_t          packed {z, v, n} result flags
//   chunk_width()    carry-chunk width WIDTH/STAGES, or 0 when the pair is illegal
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Returns 0 for an illegal WIDTH/STAGES pair so the top can stop elaboration.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1 || stages > 4 || width < stages || (width % stages) != 0)
      return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - one registered CW-bit adder slice of the add/sub pipeline
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             clears the valid bit on the next edge (wins over load)
//   load              capture a+b+cin and mark the slice full
//   drain             contents move on this cycle; slice empties unless reloaded
//   a, b, cin         slice operands (b already inverted for subtract) and carry in
//   sum, cout, valid  registered slice sum, carry out and occupancy
module addsub_chunk #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load,
  input  logic          drain,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          valid
);

  logic [CW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (load)
        valid <= 1'b1;
      else if (drain)
        valid <= 1'b0;

      if (load) begin
        sum  <= total[CW-1:0];
        cout <= total[CW];
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined add/subtract unit with Z/V/N flags and signed/unsigned mode
//
// Optional feature macro: ADDSUB_PIPE_SAT_EN (adds the sat port and result clamping).
//
// Parameters: WIDTH operand width (divisible by STAGES), STAGES pipeline depth 1..4.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of every in-flight beat
//   in_valid, in_ready  operand handshake
//   a, b, sub, sign     operands, 1 = subtract, 1 = signed flag rules
//   sat                 clamp on overflow (ADDSUB_PIPE_SAT_EN only)
//   out_valid, out_ready result handshake
//   dout, z, v, n       result and zero/overflow/negative flags
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int CW = chunk_width(WIDTH, STAGES);
  localparam int LS = STAGES - 1;

  if (CW == 0) begin : g_bad_cfg
    $error("addsub_pipe: STAGES must be 1..4 and divide WIDTH");
  end

  logic [STAGES-1:0] vld, adv, ld, cin, cout_q;
  logic [CW-1:0]     ca [STAGES];
  logic [CW-1:0]     cb [STAGES];
  logic [CW-1:0]     sum_q [STAGES];

  // Per-stage side registers: operands for the chunks still to come,
  // result chunks already produced, and the beat's own mode bits.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, lo_q, word;
  logic [STAGES-1:0]            sub_q, sign_q;
`ifdef ADDSUB_PIPE_SAT_EN
  logic [STAGES-1:0]            sat_q;
`endif

  // Handshake: a stage advances when it is full and the next one is empty or
  // advancing too; the last stage advances on out_ready.
  always_comb begin
    adv = '0;
    ld  = '0;
    adv[LS] = vld[LS] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
    ld[0] = in_valid & (~vld[0] | adv[0]) & ~flush;
    for (int k = 1; k < STAGES; k++)
      ld[k] = adv[k-1];
  end

  assign in_ready  = ~vld[0] | adv[0];
  assign out_valid = vld[LS];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is A + ~B + 1: invert B and inject the +1 as carry in.
      assign ca[k]  = a[k*CW +: CW];
      assign cb[k]  = b[k*CW +: CW] ^ {CW{sub == OP_SUB}};
      assign cin[k] = (sub == OP_SUB);
    end else begin : g_next
      assign ca[k]  = a_q[k-1][k*CW +: CW];
      assign cb[k]  = b_q[k-1][k*CW +: CW] ^ {CW{sub_q[k-1] == OP_SUB}};
      assign cin[k] = cout_q[k-1];
    end

    addsub_chunk #(.CW(CW)) u_chunk (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .load  (ld[k]),
      .drain (adv[k]),
      .a     (ca[k]),
      .b     (cb[k]),
      .cin   (cin[k]),
      .sum   (sum_q[k]),
      .cout  (cout_q[k]),
      .valid (vld[k])
    );
  end

  // Result word seen at each stage: lower chunks from the side register with
  // this stage's freshly registered chunk dropped into place.
  always_comb begin
    word = lo_q;
    for (int k = 0; k < STAGES; k++)
      word[k][k*CW +: CW] = sum_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      lo_q   <= '0;
      sub_q  <= '0;
      sign_q <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
      sat_q  <= '0;
`endif
    end else begin
      if (ld[0]) begin
        a_q[0]    <= a;
        b_q[0]    <= b;
        lo_q[0]   <= '0;
        sub_q[0]  <= sub;
        sign_q[0] <= sign;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q[0]  <= sat;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          a_q[k]    <= a_q[k-1];
          b_q[k]    <= b_q[k-1];
          lo_q[k]   <= word[k-1];
          sub_q[k]  <= sub_q[k-1];
          sign_q[k] <= sign_q[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
          sat_q[k]  <= sat_q[k-1];
`endif
        end
      end
    end
  end

  // Only parts of the side registers feed later logic.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, lo_q};

  // Flags from the last stage, forced low while it holds no beat.
  logic [WIDTH-1:0] res;
  logic             c, a_msb, b_msb, r_msb, s_ovf, is_sub;
  flags_t           fl;

  assign res    = word[LS];
  assign is_sub = (sub_q[LS] == OP_SUB);
  // Chunk carry out is inverted on subtract: bit WIDTH of the extended sum is the borrow.
  assign c      = is_sub ? ~cout_q[LS] : cout_q[LS];
  assign a_msb  = a_q[LS][WIDTH-1];
  assign b_msb  = b_q[LS][WIDTH-1];
  assign r_msb  = res[WIDTH-1];
  assign s_ovf  = (is_sub ? (a_msb != b_msb) : (a_msb == b_msb)) & (r_msb != a_msb);

  always_comb begin
    fl = '0;
    if (vld[LS]) begin
      fl.z = (res == '0) & ~c;
      if (sign_q[LS]) begin
        fl.v = s_ovf;
        fl.n = r_msb ^ s_ovf;
      end else begin
        fl.v = c;
        fl.n = is_sub & c;
      end
    end
  end

  assign z = fl.z;
  assign v = fl.v;
  assign n = fl.n;

`ifdef ADDSUB_PIPE_SAT_EN
  // Flags stay those of the wrapped sum; only dout is clamped.
  always_comb begin
    dout = res;
    if (sat_q[LS] & fl.v) begin
      if (sign_q[LS])
        dout = fl.n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        dout = is_sub ? '0 : '1;
    end
  end
`else
  assign dout = res;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - self-checking bench for addsub_pipe (WIDTH=32, STAGES=2)
module tb_addsub_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        sign = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        z, v, n;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sign      (sign),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .z         (z),
    .v         (v),
    .n         (n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        v;
    logic        n;
  } res_t;

  res_t model_q[$];
  int   total  = 0;
  int   passes = 0;
  int   popped = 0;

  // Reference: exact integer arithmetic, flags from the mathematical result.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic g, input logic t);
    logic [32:0] s33;
    longint      sx, sy, tr;
    res_t        r;
    s33 = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    tr  = s ? (sx - sy) : (sx + sy);
    r.d = s33[31:0];
    r.z = (s33 == 33'd0);
    if (g) begin
      r.v = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
      r.n = (tr < 0);
    end else begin
      r.v = s33[32];
      r.n = s & s33[32];
    end
    if (t && r.v) begin
      if (g) r.d = r.n ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else   r.d = s ? 32'h0 : 32'hFFFF_FFFF;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Compare process: every cycle a result is presented it must match the model's head.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      if (out_valid) begin
        if (model_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          check("stream_dout", dout, model_q[0].d);
          check("stream_zvn", {z, v, n}, {model_q[0].z, model_q[0].v, model_q[0].n});
          if (out_ready) begin
            void'(model_q.pop_front());
            popped++;
          end
        end
      end
      if (flush) model_q.delete();
      else if (in_valid && in_ready) model_q.push_back(model(a, b, sub, sign, sat));
    end
  end

  // Single beat into an empty pipe; latency and hand-computed result pinned.
  task automatic one(input logic [31:0] x, input logic [31:0] y, input logic s,
                     input logic g, input logic t, input logic [31:0] ed,
                     input logic ez, input logic ev, input logic en, input string nm);
    int lat;
    a = x; b = y; sub = s; sign = g; sat = t;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, STAGES);
    check({nm, "_dout"}, dout, ed);
    check({nm, "_zvn"}, {z, v, n}, {ez, ev, en});
    @(posedge clk); #1;
  endtask

  logic [31:0] ha [4] = '{32'h10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3};
  logic [31:0] hb [4] = '{32'h20, 32'h1, 32'h1, 32'h8};
  logic        hs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        hg [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, drop_at, p0, guard;
    logic acc;
    res_t r0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_dout", dout, 32'h0);
    check("reset_zvn", {z, v, n}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1'b1);

    one(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "s_add_ovf");
    one(32'h0,         32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "s_sub_minneg");
    one(32'h5,         32'h7,         1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, "u_sub_borrow");
    one(32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, "u_add_carry");
    one(32'h9,         32'h9,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, "u_sub_zero");
    one(32'h5,         32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 32'h2,         1'b0, 1'b0, 1'b0, "s_add_mixed");
    one(32'h3,         32'h5,         1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, "s_sub_neg");
    one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, "s_add_negovf");
    one(32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "u_chunk_carry");
`ifdef ADDSUB_PIPE_SAT_EN
    one(32'h7FFF_FFF0, 32'h20,        1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "sat_s_add");
    one(32'h3,         32'h4,         1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, "sat_u_sub");
    sat = 1'b0;
`endif

    // Backpressure: 4 mixed beats offered with out_ready low for the first cycles.
    out_ready = 1'b0;
    idx = 0; drop_at = -1; p0 = popped;
    r0 = model(ha[0], hb[0], hs[0], hg[0], 1'b0);
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      a = ha[idx]; b = hb[idx]; sub = hs[idx]; sign = hg[idx];
      in_valid = 1'b1;
      if (cyc == 6) out_ready = 1'b1;
      #3;
      if (!in_ready && drop_at < 0) drop_at = idx;
      if (cyc == 3 || cyc == 5) check("hold_dout", dout, r0.d);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("in_ready_drop_after", drop_at, 2);
    check("all_beats_accepted", idx, 4);
    guard = 0;
    while ((model_q.size() != 0 || out_valid) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stream_results_out", popped - p0, 4);

    // Flush with two beats in flight: nothing may come out afterwards.
    out_ready = 1'b0;
    a = 32'h1; b = 32'h2; sub = 1'b0; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h7; b = 32'h3; sub = 1'b1;
    @(posedge clk); #1;
    a = 32'h11; b = 32'h22; sub = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("flush_no_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Flush on an empty pipe: the beat offered alongside is dropped.
    a = 32'h44; b = 32'h55; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_drop_no_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Reset pulsed while a flagged result is on the output.
    a = 32'h7FFF_FFFF; b = 32'h1; sub = 1'b0; sign = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h5; b = 32'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_dout", dout, 32'h0);
    check("midreset_zvn", {z, v, n}, 3'b000);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_no_out_valid", out_valid, 1'b0);

    one(32'h9, 32'h9, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined add/subtract unit with Zero/Overflow/Negative flags and signed/unsigned mode. It splits the carry chain into STAGES equal chunks, one chunk per register stage, so wide operands meet timing. A valid/ready handshake carries operands in and results out. It replaces the single-cycle adder on the execute path wherever a multi-cycle or backpressured datapath is in use (multiply/divide front end, address generation).

## Interface
- WIDTH, 32, operand/result width; must be divisible by STAGES.
- STAGES, 2, pipeline depth and carry-chunk count; legal values 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all in-flight operations.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  unit accepts the beat this cycle.
- a, b  in  WIDTH each  operands.
- sub  in  1  0 = A+B, 1 = A−B.
- sign  in  1  1 = signed flag rules, 0 = unsigned.
- sat  in  1  saturate on overflow (present only with ADDSUB_PIPE_SAT_EN).
- out_valid  out  1  result beat is present.
- out_ready  in  1  consumer takes the result.
- dout  out  WIDTH  result.
- z, v, n  out  1 each  zero, overflow, negative.

## Operation
- Arithmetic is done at WIDTH+1 bits: s = {0,A} + (sub ? ~{0,B}+1 : {0,B}). dout = s[WIDTH-1:0]; c = s[WIDTH], which is the carry on add and the borrow (A<B) on sub.
- z = (dout == 0) & ~c. The full WIDTH+1 sum must be zero.
- Signed v: for add, (A[msb]==B[msb]) & (dout[msb]!=A[msb]); for sub, (A[msb]!=B[msb]) & (dout[msb]!=A[msb]). This rule is exact for B = most-negative.
- Unsigned v = c.
- Signed n = dout[msb] ^ v, which is the true sign of the result.
- Unsigned n = sub & c.
- Stage k (0..STAGES-1) adds bits [k·CW +: CW], with CW = WIDTH/STAGES, using the carry registered from stage k−1. Lower result chunks and control bits (sub, sign, sat, operand MSBs) travel alongside in registers.
- Flags are formed in the last stage.
- Every beat is tagged by its own sub/sign bits. Back-to-back beats may mix modes freely.

## Timing
- Latency is STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput is one beat per cycle.
- Each stage has a valid bit. A stage loads when it is empty or when its contents move on in the same cycle.
- in_ready = ~valid[0] | advance[0]. in_ready is combinational from out_ready through the advance chain; there is no skid buffer.
- When out_valid & ~out_ready: dout, z, v, n and all stage contents hold stable. The pipeline fills up to STAGES beats, then in_ready = 0.
- Simultaneous output handoff and input accept at full occupancy: both occur and occupancy is unchanged.
- flush clears all valid bits on the next edge. out_valid = 0 the next cycle, and an input offered in the flush cycle is dropped. flush has priority over accept.
- Reset, including reset asserted mid-operation: all valid bits = 0, out_valid = 0, dout = 0, z = 0, v = 0, n = 0. Carries are cleared. in_ready = 1 one cycle after reset deasserts.
- STAGES = 1: a single registered stage with latency 1.

## Configuration
- ADDSUB_PIPE_SAT_EN defined:
  - The sat port exists and is carried with each beat.
  - If sat & v, dout is clamped. Signed clamps to the max positive value on positive overflow, otherwise to the most-negative value. Unsigned add clamps to all ones; unsigned sub clamps to 0.
  - Flags are computed from the unclamped sum, so v still reports overflow.
- Not defined: there is no sat port, no clamp logic, and dout is always the wrapped sum.

## Structure
- Shared package alu_pkg holds:
  - the op encoding constants (OP_ADD = 0, OP_SUB = 1);
  - the flag struct (z, v, n);
  - the localparam function that computes CW and checks WIDTH % STAGES == 0 at elaboration.
- One sub-module, addsub_chunk: registered CW-bit adder slice with carry in/out, valid, and a load enable. It is instantiated STAGES times in a generate loop. Flag and clamp logic live in the top.

## Test plan
- WIDTH=32, STAGES=2, sign=1, add 0x7FFFFFFF + 1 -> after 2 cycles: dout=0x80000000, v=1, n=0, z=0.
- Signed sub 0 − 0x80000000 -> dout=0x80000000, v=1, n=0.
- Unsigned sub 5 − 7 -> dout=0xFFFFFFFE, v=1, n=1.
- Unsigned add 0xFFFFFFFF + 1 -> dout=0, v=1, z=0. Unsigned sub 9 − 9 -> z=1, v=0.
- Handshake: stream 4 mixed beats while out_ready is held low from cycle 2 -> in_ready drops after 2 accepted beats, dout holds stable, all 4 results emerge in order once out_ready=1. Then assert flush with 2 beats in flight -> no out_valid follows.
- With ADDSUB_PIPE_SAT_EN: signed sat add 0x7FFFFFF0 + 0x20 -> dout=0x7FFFFFFF, v=1. Unsigned sat sub 3 − 4 -> dout=0. Also pulse rst_n mid-stream -> all outputs 0 immediately.
